// File: rtl/dmem_lsu.sv
// RV32I data memory with byte-lane stores, sign/zero-extended async loads, misalign detect.
// Stores/counters commit on rising clk; DMEM_MISALIGN_TRAP_EN selects trap vs force-align.
module dmem_lsu #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        fault,
   output logic [31:0] fault_addr,
   output logic [15:0] store_cnt
);

   logic [31:0]   r_mem [DEPTH];
   logic [15:0]   r_store_cnt;

   logic [AW-1:0] w_idx;
   logic          w_half;
   logic          w_word;
   logic          w_mis_raw;
   logic          w_block;
   logic [1:0]    w_off;
   logic          w_st_vld;
   logic [3:0]    w_be;
   logic [31:0]   w_wdat;
   logic [31:0]   w_rword;
   logic [15:0]   w_lane;
   logic [31:0]   w_fmt;

   assign w_idx = addr[AW+1:2];

   // A 101 code is a halfword only when it is a load; as a store it is simply invalid.
   assign w_half    = (funct3 == 3'b001) || ((funct3 == 3'b101) && !wr_en);
   assign w_word    = (funct3 == 3'b010);
   assign w_mis_raw = (w_half && addr[0]) || (w_word && (addr[1:0] != 2'b00));
   assign misalign  = (rd_en | wr_en) & w_mis_raw;

   assign w_off = w_word ? 2'b00 : (w_half ? {addr[1], 1'b0} : addr[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_block = w_mis_raw;
`else
   assign w_block = 1'b0;
`endif

   always_comb begin
      w_be     = 4'b0000;
      w_wdat   = wdata;
      w_st_vld = 1'b0;
      case (funct3)
         3'b000: begin
            w_be     = 4'b0001 << w_off;
            w_wdat   = {4{wdata[7:0]}};
            w_st_vld = wr_en && !w_block;
         end
         3'b001: begin
            w_be     = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdat   = {2{wdata[15:0]}};
            w_st_vld = wr_en && !w_block;
         end
         3'b010: begin
            w_be     = 4'b1111;
            w_wdat   = wdata;
            w_st_vld = wr_en && !w_block;
         end
         default: begin
            w_be     = 4'b0000;
            w_wdat   = wdata;
            w_st_vld = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_st_vld) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_store_cnt <= '0;
      end else if (w_st_vld) begin
         r_store_cnt <= r_store_cnt + 16'd1;
      end
   end

   assign store_cnt = r_store_cnt;
   assign w_rword   = r_mem[w_idx];

   always_comb begin
      w_lane = w_rword[15:0];
      case (w_off)
         2'd0:    w_lane = w_rword[15:0];
         2'd1:    w_lane = w_rword[23:8];
         2'd2:    w_lane = w_rword[31:16];
         default: w_lane = {8'h00, w_rword[31:24]};
      endcase
   end

   always_comb begin
      w_fmt = '0;
      case (funct3)
         3'b000:  w_fmt = {{24{w_lane[7]}}, w_lane[7:0]};
         3'b001:  w_fmt = {{16{w_lane[15]}}, w_lane[15:0]};
         3'b010:  w_fmt = w_rword;
         3'b100:  w_fmt = {24'h0, w_lane[7:0]};
         3'b101:  w_fmt = {16'h0, w_lane[15:0]};
         default: w_fmt = '0;
      endcase
   end

   assign rdata = (rd_en && !wr_en && !w_block && !rst) ? w_fmt : 32'h0;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic        r_fault;
   logic [31:0] r_fault_addr;

   // Only the first misaligned access is recorded; the record is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fault      <= 1'b0;
         r_fault_addr <= '0;
      end else if (misalign && !r_fault) begin
         r_fault      <= 1'b1;
         r_fault_addr <= addr;
      end
   end

   assign fault      = r_fault;
   assign fault_addr = r_fault_addr;
`else
   logic w_unused;

   assign w_unused   = &{1'b0, addr[31:AW+2]};
   assign fault      = 1'b0;
   assign fault_addr = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: queued expectations checked by a negedge monitor plus inline checks.
// Latency: checks sample combinational outputs mid-cycle and registered outputs after the edge.
// No backpressure: stimulus is driven one access per cycle.
module tb_dmem_lsu;

    localparam int K_RD  = 0;
    localparam int K_CNT = 1;
    localparam int K_MIS = 2;
    localparam int K_FLT = 3;
    localparam int K_FA  = 4;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_X  = 3'b011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        misalign;
    logic        fault;
    logic [31:0] fault_addr;
    logic [15:0] store_cnt;

    typedef struct {
        string       nm;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_vld = 1'b0;

    dmem_lsu #(.DEPTH(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .funct3     (funct3),
        .rdata      (rdata),
        .misalign   (misalign),
        .fault      (fault),
        .fault_addr (fault_addr),
        .store_cnt  (store_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pick(int k);
        case (k)
            K_RD:    return rdata;
            K_CNT:   return {16'h0, store_cnt};
            K_MIS:   return {31'h0, misalign};
            K_FLT:   return {31'h0, fault};
            default: return fault_addr;
        endcase
    endfunction

    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        if (chk_vld) begin
            while (sb_q.size() > 0) begin
                c   = sb_q.pop_front();
                act = pick(c.kind);
                n_tests++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", c.nm, act, c.exp);
                end
            end
        end
    end

    task automatic push(input string nm, input int k, input logic [31:0] e);
        chk_t c;
        c.nm   = nm;
        c.kind = k;
        c.exp  = e;
        sb_q.push_back(c);
    endtask

    task automatic drv(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
        rd_en  = r;
        wr_en  = w;
        funct3 = f;
        addr   = a;
        wdata  = d;
    endtask

    task automatic step();
        chk_vld = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drv(1'b1, 1'b0, F_W, 32'h10, 32'h0);
        push("rst_rdata", K_RD, 32'h0);
        push("rst_cnt", K_CNT, 32'h0);
        push("rst_fault", K_FLT, 32'h0);
        push("rst_faddr", K_FA, 32'h0);
        push("rst_mis", K_MIS, 32'h0);
        step();
        rst = 1'b0;

        drv(1'b0, 1'b1, F_W, 32'h10, 32'h11223344);
        push("sw10_mis", K_MIS, 32'h0);
        step();
        drv(1'b1, 1'b0, F_W, 32'h10, 32'h0);
        push("lw10", K_RD, 32'h11223344);
        push("cnt1", K_CNT, 32'd1);
        step();

        drv(1'b0, 1'b1, F_B, 32'h13, 32'h000000AB);
        push("sb13_mis", K_MIS, 32'h0);
        step();
        drv(1'b1, 1'b0, F_W, 32'h10, 32'h0);
        push("lw10_after_sb", K_RD, 32'hAB223344);
        push("cnt2", K_CNT, 32'd2);
        step();
        drv(1'b1, 1'b0, F_B, 32'h13, 32'h0);
        push("lb13", K_RD, 32'hFFFFFFAB);
        step();
        drv(1'b1, 1'b0, F_BU, 32'h13, 32'h0);
        push("lbu13", K_RD, 32'h000000AB);
        step();

        drv(1'b0, 1'b1, F_H, 32'h22, 32'h00008001);
        step();
        drv(1'b1, 1'b0, F_H, 32'h22, 32'h0);
        push("lh22", K_RD, 32'hFFFF8001);
        push("cnt3", K_CNT, 32'd3);
        step();
        drv(1'b1, 1'b0, F_HU, 32'h22, 32'h0);
        push("lhu22", K_RD, 32'h00008001);
        step();
        drv(1'b1, 1'b0, F_H, 32'h20, 32'h0);
        push("lh20", K_RD, 32'h00000000);
        step();

        drv(1'b0, 1'b0, F_W, 32'h10, 32'h0);
        push("no_rd_en", K_RD, 32'h0);
        step();
        drv(1'b1, 1'b0, F_X, 32'h10, 32'h0);
        push("bad_load_code", K_RD, 32'h0);
        step();
        drv(1'b0, 1'b1, F_X, 32'h10, 32'hFFFFFFFF);
        step();
        drv(1'b1, 1'b0, F_W, 32'h10, 32'h0);
        push("bad_store_nowrite", K_RD, 32'hAB223344);
        push("bad_store_nocnt", K_CNT, 32'd3);
        step();

        drv(1'b1, 1'b1, F_W, 32'h20, 32'h0BADF00D);
        push("rd_wr_rdata0", K_RD, 32'h0);
        step();
        drv(1'b1, 1'b0, F_W, 32'h20, 32'h0);
        push("lw20_store_won", K_RD, 32'h0BADF00D);
        push("cnt4", K_CNT, 32'd4);
        step();

        drv(1'b0, 1'b1, F_W, 32'h0, 32'h01020304);
        step();
        // Read word 0 in the first half of the cycle, then turn it into the aliasing store.
        drv(1'b1, 1'b0, F_W, 32'h0, 32'h0);
        push("same_cycle_old", K_RD, 32'h01020304);
        push("cnt5", K_CNT, 32'd5);
        chk_vld = 1'b1;
        @(negedge clk);
        #1;
        drv(1'b0, 1'b1, F_W, 32'h400, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        drv(1'b1, 1'b0, F_W, 32'h0, 32'h0);
        #1;
        n_tests++;
        if (rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wrap_new_now: got 0x%08h, expected 0x%08h", rdata, 32'hDEADBEEF);
        end
        push("wrap_new", K_RD, 32'hDEADBEEF);
        push("cnt6", K_CNT, 32'd6);
        step();

        drv(1'b0, 1'b1, F_W, 32'h15, 32'hCAFEF00D);
        push("sw15_mis", K_MIS, 32'h1);
        step();
        drv(1'b1, 1'b0, F_W, 32'h14, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        push("sw15_suppressed", K_RD, 32'h0);
        push("sw15_nocnt", K_CNT, 32'd6);
        push("fault_set", K_FLT, 32'h1);
        push("faddr15", K_FA, 32'h15);
`else
        push("sw15_aligned", K_RD, 32'hCAFEF00D);
        push("sw15_cnt", K_CNT, 32'd7);
        push("fault_tied", K_FLT, 32'h0);
        push("faddr_tied", K_FA, 32'h0);
`endif
        step();

        drv(1'b1, 1'b0, F_H, 32'h31, 32'h0);
        push("lh31_mis", K_MIS, 32'h1);
        push("lh31_rdata", K_RD, 32'h0);
        step();
        drv(1'b1, 1'b0, F_H, 32'h13, 32'h0);
        push("lh13_mis", K_MIS, 32'h1);
`ifdef DMEM_MISALIGN_TRAP_EN
        push("lh13_trap", K_RD, 32'h0);
        push("faddr_sticky", K_FA, 32'h15);
`else
        push("lh13_aligned", K_RD, 32'hFFFFAB22);
        push("faddr_still0", K_FA, 32'h0);
`endif
        step();
        drv(1'b1, 1'b0, F_B, 32'h15, 32'h0);
        push("lb15_mis", K_MIS, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        push("lb15", K_RD, 32'h0);
`else
        push("lb15", K_RD, 32'hFFFFFFF0);
`endif
        step();

        drv(1'b0, 1'b1, F_W, 32'h10, 32'h12345678);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (store_cnt !== 16'h0 || fault !== 1'b0 || fault_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_now: cnt=0x%04h fault=%0b faddr=0x%08h, expected all 0",
                     store_cnt, fault, fault_addr);
        end
        drv(1'b1, 1'b0, F_W, 32'h10, 32'h0);
        #1;
        n_tests++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_rdata_now: got 0x%08h, expected 0x%08h", rdata, 32'h0);
        end
        push("midrst_rdata", K_RD, 32'h0);
        push("midrst_cnt", K_CNT, 32'h0);
        push("midrst_fault", K_FLT, 32'h0);
        push("midrst_faddr", K_FA, 32'h0);
        chk_vld = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        drv(1'b1, 1'b0, F_W, 32'h10, 32'h0);
        push("post_rst_mem10", K_RD, 32'h0);
        push("post_rst_cnt", K_CNT, 32'h0);
        step();
        drv(1'b1, 1'b0, F_W, 32'h0, 32'h0);
        push("post_rst_mem0", K_RD, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_tests < 12) begin
            $display("FAIL too few checks: %0d run, expected at least 12", n_tests);
            $fatal(1);
        end else if (n_fail != 0) begin
            $display("FAIL %0d of %0d checks failed", n_fail, n_tests);
            $fatal(1);
        end else begin
            $display("PASS");
        end
        $finish;
    end

endmodule
